fifo_wr_ctrl: RTL

Write-side pointer and flag controller for the reader's asynchronous sample FIFO. Owns the binary and Gray-coded write pointers and synchronizes the remote read-side Gray pointer into the write clock domain. Converts that pointer back to binary and produces write enable/address for the dual-port RAM, plus full, almost-full, fill-level and overflow status. Sits between the demodulator's sample output and the FIFO storage array.

---
 rtl/fifo_wr_ctrl_pkg.sv | 33 +++
 rtl/fifo_wr_ctrl_ptr_sync.sv | 26 ++
 rtl/fifo_wr_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared async-FIFO helpers: pointer width, Gray conversions and the full compare.
// Values narrower than ptr_t must be passed in zero-extended.
package fifo_wr_ctrl_pkg;

   localparam int MAX_PTR_W = 32;

   typedef logic [MAX_PTR_W-1:0] ptr_t;

   function automatic int ptr_width(input int addr_width);
      return addr_width + 1;
   endfunction

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
      for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Full when the pointers differ only in the two MSBs of a width-bit Gray pointer.
   function automatic logic ptr_full(input ptr_t wr_gray, input ptr_t rd_gray, input int width);
      ptr_t mask;
      mask = ptr_t'(3) << (width - 2);
      return wr_gray == (rd_gray ^ mask);
   endfunction

endpackage

// File: rtl/fifo_wr_ctrl_ptr_sync.sv
// Multi-flop synchronizer for a Gray pointer crossing clock domains.
// Shared by the write-side and read-side FIFO controllers.
module ptr_sync #(
   parameter int WIDTH       = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;

   // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage <= '0;
      end else begin
         stage <= {stage[SYNC_STAGES-2:0], d};
      end
   end

   assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer/flag controller of the sample FIFO: owns the write pointers,
// synchronizes the read Gray pointer and derives full, almost_full, fill level and overflow.
module fifo_wr_ctrl
   import fifo_wr_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AF_MARGIN   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
   input  logic                  clr_overflow,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [ADDR_WIDTH:0]   wr_ptr_gray,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   fill_level,
   output logic                  overflow
);

   localparam int            PW       = ptr_width(ADDR_WIDTH);
   localparam int            DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

   logic [PW-1:0] wr_bin;
   logic [PW-1:0] bin_nxt;
   logic [PW-1:0] gray_nxt;
   logic [PW-1:0] rq;
   logic [PW-1:0] rq_bin;
   logic [PW-1:0] fill_nxt;
   logic          accept;

   ptr_sync #(
      .WIDTH       (PW),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rd_sync (
      .clk (clk),
      .rst (rst),
      .d   (rd_ptr_gray),
      .q   (rq)
   );

   assign accept   = wr_en && !full;
   assign mem_we   = accept;
   assign wr_addr  = wr_bin[ADDR_WIDTH-1:0];
   assign bin_nxt  = wr_bin + PW'(accept);
   assign gray_nxt = PW'(bin2gray(ptr_t'(bin_nxt)));
   assign rq_bin   = PW'(gray2bin(ptr_t'(rq)));
   assign fill_nxt = bin_nxt - rq_bin;

   // Flags are computed from the post-write pointer so they land in the same cycle as the write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bin      <= '0;
         wr_ptr_gray <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         fill_level  <= '0;
      end else begin
         wr_bin      <= bin_nxt;
         wr_ptr_gray <= gray_nxt;
         full        <= ptr_full(ptr_t'(gray_nxt), ptr_t'(rq), PW);
         almost_full <= fill_nxt >= AF_LEVEL;
         fill_level  <= fill_nxt;
      end
   end

   // A refused write outranks a clear in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (wr_en && full) begin
         overflow <= 1'b1;
      end else if (clr_overflow) begin
         overflow <= 1'b0;
      end
   end

endmodule
